// File: rtl/npu_instr_sequencer_pkg.sv
// Shared NPU definitions: widths, opcodes
// and the sequencer state encoding.
package npu_instr_sequencer_pkg;

  localparam int NPU_INSTR_WIDTH  = 48;
  localparam int NPU_MEM_AWIDTH   = 10;
  localparam int NPU_OPCODE_WIDTH = 4;
  localparam int NPU_DRAIN_CYCLES = 16;

  localparam int NPU_OP_NOP       = 0;
  localparam int NPU_OP_LOAD      = 1;
  localparam int NPU_OP_MATMUL    = 2;
  localparam int NPU_OP_STORE     = 4;
  localparam int NPU_OP_END_CHAIN = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/npu_instr_sequencer_if.sv
// Host load/control and NPU fetch bundle
// of the instruction sequencer.
interface npu_instr_sequencer_if
  import npu_instr_sequencer_pkg::*;
#(
  parameter int IW = NPU_INSTR_WIDTH,
  parameter int AW = NPU_MEM_AWIDTH
);
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [IW-1:0] load_data;
  logic [AW:0]   prog_len;
  logic          start;
  logic          abort;
  logic          npu_get_instr;
  logic [AW-1:0] npu_get_instr_addr;
  logic [IW-1:0] instruction;
  logic          instr_valid;
  logic          busy;
  logic          done;
  logic [AW:0]   issued_count;
  logic          err_overrun;
  logic          err_load_busy;

  modport master (
    output load_en, load_addr, load_data,
    output prog_len, start, abort,
    output npu_get_instr, npu_get_instr_addr,
    input  instruction, instr_valid,
    input  busy, done, issued_count,
    input  err_overrun, err_load_busy
  );

  modport slave (
    input  load_en, load_addr, load_data,
    input  prog_len, start, abort,
    input  npu_get_instr, npu_get_instr_addr,
    output instruction, instr_valid,
    output busy, done, issued_count,
    output err_overrun, err_load_busy
  );
endinterface

// File: rtl/npu_instr_ram.sv
// Instruction store: one write port and one
// registered read port; contents survive reset.
module npu_instr_ram #(
  parameter int DW = 48,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] rdata_d;

  // read data only moves on an enabled read
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  // array write and read register
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/npu_instr_sequencer.sv
// Run controller that serves instruction fetches
// to the NPU and drains after an END_CHAIN.
module npu_instr_sequencer
  import npu_instr_sequencer_pkg::*;
#(
  parameter int INSTR_WIDTH      = NPU_INSTR_WIDTH,
  parameter int INSTR_MEM_AWIDTH = NPU_MEM_AWIDTH,
  parameter int OPCODE_WIDTH     = NPU_OPCODE_WIDTH,
  parameter int END_CHAIN_OP     = NPU_OP_END_CHAIN,
  parameter int DRAIN_CYCLES     = NPU_DRAIN_CYCLES
) (
  input logic clk,
  input logic rst,
  npu_instr_sequencer_if.slave bus
);

  localparam int IW  = INSTR_WIDTH;
  localparam int AW  = INSTR_MEM_AWIDTH;
  localparam int OW  = OPCODE_WIDTH;
  localparam int DCW =
    (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [OW-1:0] END_OP =
    OW'(END_CHAIN_OP);
  localparam logic [IW-1:0] END_WORD =
    {END_OP, (IW-OW)'(0)};
  localparam logic [DCW-1:0] DRAIN_LAST =
    DCW'(DRAIN_CYCLES - 1);

  seq_state_e     state_q, state_d;
  logic [AW:0]    len_q, len_d;
  logic [AW:0]    cnt_q, cnt_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic           vld_q, vld_d;
  logic           ovr_q, ovr_d;
  logic [IW-1:0]  hold_q, hold_d;
  logic           eovr_q, eovr_d;
  logic           eld_q, eld_d;

  logic [IW-1:0]  ram_rdata;
  logic [IW-1:0]  word;
  logic           load_ok;
  logic           load_open;
  logic           fetch;
  logic           oob;
  logic           is_end;

  // host may write only while no run is active
  always_comb begin
    load_open = (state_q == ST_IDLE) ||
                (state_q == ST_DONE);
    load_ok   = bus.load_en && load_open;
    fetch     = (state_q == ST_RUN) &&
                bus.npu_get_instr && !bus.abort;
    oob       = {1'b0, bus.npu_get_instr_addr}
                >= len_q;
    word      = ovr_q ? END_WORD : ram_rdata;
    is_end    = vld_q &&
                (word[IW-1 -: OW] == END_OP);
  end

  npu_instr_ram #(
    .DW (IW),
    .AW (AW)
  ) u_ram (
    .clk   (clk),
    .we    (load_ok),
    .waddr (bus.load_addr),
    .wdata (bus.load_data),
    .re    (fetch),
    .raddr (bus.npu_get_instr_addr),
    .rdata (ram_rdata)
  );

  // next state, fetch pipeline and run bookkeeping
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    vld_d   = fetch;
    ovr_d   = fetch ? oob : ovr_q;
    hold_d  = vld_q ? word : hold_q;
    eovr_d  = eovr_q | (fetch & oob);
    eld_d   = eld_q |
              (bus.load_en & ~load_open);
    if (fetch && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          len_d  = bus.prog_len;
          cnt_d  = '0;
          eovr_d = 1'b0;
          eld_d  = 1'b0;
          state_d = (bus.prog_len == '0) ?
                    ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          state_d = ST_DONE;
        end else if (is_end) begin
          state_d = ST_DRAIN;
          dcnt_d  = '0;
        end
      end
      ST_DRAIN: begin
        if (bus.abort) begin
          state_d = ST_DONE;
        end else if (dcnt_q == DRAIN_LAST) begin
          state_d = ST_DONE;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
      hold_q  <= '0;
      eovr_q  <= 1'b0;
      eld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
      hold_q  <= hold_d;
      eovr_q  <= eovr_d;
      eld_q   <= eld_d;
    end
  end

  assign bus.instruction   = vld_q ? word : hold_q;
  assign bus.instr_valid   = vld_q;
  assign bus.busy          = (state_q == ST_RUN) ||
                             (state_q == ST_DRAIN);
  assign bus.done          = (state_q == ST_DONE);
  assign bus.issued_count  = cnt_q;
  assign bus.err_overrun   = eovr_q;
  assign bus.err_load_busy = eld_q;

endmodule

// File: tb/tb_npu_instr_sequencer.sv
// Randomised run-level bench for the
// NPU instruction sequencer.
module tb_npu_instr_sequencer;

  localparam int INF = 100000;
  localparam logic [47:0] END_W = 48'hC000_0000_0000;

  logic clk = 1'b0;
  logic rst;

  npu_instr_sequencer_if bus ();

  npu_instr_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [47:0] mem_m [1024];
  logic [47:0] last_w;

  bit g_rq [64];
  int g_ra [64];
  int g_tn;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] rnd_word();
    return {16'($urandom()), 32'($urandom())};
  endfunction

  task automatic load_word(input int a,
                           input logic [47:0] d);
    bus.load_en   = 1'b1;
    bus.load_addr = 10'(a);
    bus.load_data = d;
    tick();
    bus.load_en = 1'b0;
    mem_m[a] = d;
  endtask

  // Run one program: expected pulses derive from
  // request schedule, END position and drain length.
  task automatic run_prog(input int len,
                          input bit ld_busy,
                          input bit ld_start,
                          input int ca,
                          input int rst_off);
    bit          ev [160];
    logic [47:0] ew [160];
    int te, dc, rc, lastc, cnt;
    bit ovr;
    int lda;
    logic [47:0] ldw;
    ovr = 0;
    if (ld_start) begin
      lda = $urandom_range(0, len);
      ldw = rnd_word();
      bus.load_en   = 1'b1;
      bus.load_addr = 10'(lda);
      bus.load_data = ldw;
      mem_m[lda] = ldw;
    end
    for (int i = 0; i < 160; i++) begin
      ev[i] = 0;
      ew[i] = '0;
    end
    te = INF;
    for (int c = 0; c < 159; c++) begin
      if (te == INF && ev[c] &&
          ew[c][47:44] == 4'd12) te = c;
      if (len > 0 && c < g_tn && g_rq[c] &&
          c <= te && c < ca) begin
        ev[c+1] = 1;
        if (g_ra[c] < len) begin
          ew[c+1] = mem_m[10'(g_ra[c])];
        end else begin
          ew[c+1] = END_W;
          ovr = 1;
        end
      end
    end
    if (len == 0) dc = 0;
    else if (ca <= te + 16) dc = ca + 1;
    else dc = te + 17;
    rc = (rst_off >= 0) ? te + rst_off : INF;
    lastc = (rc < INF) ? rc + 4 : dc + 1;
    bus.start    = 1'b1;
    bus.prog_len = 11'(len);
    tick();
    bus.start   = 1'b0;
    bus.load_en = 1'b0;
    cnt = 0;
    for (int c = 0; c <= lastc; c++) begin
      if (c > rc) begin
        last_w = '0;
        chk("rst_vld", 64'(bus.instr_valid), 64'(0));
        chk("rst_ins", 64'(bus.instruction), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_cnt", 64'(bus.issued_count), 64'(0));
        chk("rst_eovr", 64'(bus.err_overrun), 64'(0));
      end else begin
        if (ev[c]) begin
          if (cnt < 2047) cnt++;
          last_w = ew[c];
        end
        chk("vld", 64'(bus.instr_valid), 64'(ev[c]));
        chk("ins", 64'(bus.instruction), 64'(last_w));
        chk("busy", 64'(bus.busy), 64'(c < dc));
        chk("done", 64'(bus.done), 64'(c == dc));
        chk("cnt", 64'(bus.issued_count), 64'(cnt));
        if (c == dc) begin
          chk("err_ovr", 64'(bus.err_overrun), 64'(ovr));
          chk("err_ld", 64'(bus.err_load_busy),
              64'(ld_busy));
        end
      end
      bus.npu_get_instr = (c < g_tn) ? g_rq[c] : 1'b0;
      bus.npu_get_instr_addr =
        (c < g_tn) ? 10'(g_ra[c]) : 10'd0;
      bus.abort = (c == ca);
      rst = (c == rc);
      bus.load_en = ld_busy && (c == 0);
      bus.load_addr = 10'd7;
      bus.load_data = ~mem_m[7];
      bus.start = (c == 0) && (len > 0);
      bus.prog_len = 11'd0;
      tick();
    end
    bus.npu_get_instr = 1'b0;
    bus.abort   = 1'b0;
    bus.load_en = 1'b0;
    bus.start   = 1'b0;
    rst = 1'b0;
  endtask

  task automatic seq_sched(input int n);
    g_tn = n;
    for (int c = 0; c < n; c++) begin
      g_rq[c] = 1;
      g_ra[c] = c;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: no finish, limit hit");
    $fatal(1);
  end

  initial begin
    int len, n;
    rst = 1'b1;
    bus.load_en = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    bus.prog_len = '0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.npu_get_instr = 1'b0;
    bus.npu_get_instr_addr = '0;
    last_w = '0;
    tick();
    tick();
    chk("r_ins", 64'(bus.instruction), 64'(0));
    chk("r_vld", 64'(bus.instr_valid), 64'(0));
    chk("r_busy", 64'(bus.busy), 64'(0));
    chk("r_done", 64'(bus.done), 64'(0));
    chk("r_cnt", 64'(bus.issued_count), 64'(0));
    chk("r_eovr", 64'(bus.err_overrun), 64'(0));
    chk("r_eld", 64'(bus.err_load_busy), 64'(0));
    rst = 1'b0;
    tick();

    for (int a = 0; a < 64; a++) load_word(a, rnd_word());

    // opcodes 2,4,1,12 then back-to-back fetch
    load_word(0, {4'd2, 44'($urandom())});
    load_word(1, {4'd4, 44'($urandom())});
    load_word(2, {4'd1, 44'($urandom())});
    load_word(3, {4'd12, 44'($urandom())});
    seq_sched(4);
    run_prog(4, 0, 0, INF, -1);

    // overrun beyond program length
    load_word(5, {4'd3, 44'($urandom())});
    g_tn = 1; g_rq[0] = 1; g_ra[0] = 5;
    run_prog(2, 0, 0, INF, -1);

    // host write attempt during a run
    g_tn = 4;
    g_rq[0] = 1; g_ra[0] = 1;
    g_rq[1] = 0; g_ra[1] = 0;
    g_rq[2] = 1; g_ra[2] = 7;
    g_rq[3] = 1; g_ra[3] = 10;
    run_prog(10, 1, 0, INF, -1);
    g_tn = 2;
    g_rq[0] = 1; g_ra[0] = 7;
    g_rq[1] = 1; g_ra[1] = 9;
    run_prog(9, 0, 0, INF, -1);

    // abort two cycles after first request
    for (int a = 0; a < 8; a++)
      load_word(a, {4'd1, 44'($urandom())});
    seq_sched(8);
    run_prog(8, 0, 0, 2, -1);

    // empty program and abort while idle
    g_tn = 0;
    run_prog(0, 0, 0, INF, -1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_idle_busy", 64'(bus.busy), 64'(0));
    chk("abort_idle_done", 64'(bus.done), 64'(0));

    // reset in drain, then read the words back
    load_word(3, {4'd12, 44'($urandom())});
    seq_sched(4);
    run_prog(4, 0, 0, INF, 5);
    seq_sched(4);
    run_prog(4, 0, 0, INF, -1);

    for (int r = 0; r < 14; r++) begin
      len = $urandom_range(1, 40);
      n = $urandom_range(3, 25);
      g_tn = n;
      for (int c = 0; c < n - 1; c++) begin
        g_rq[c] = ($urandom_range(0, 2) != 0);
        g_ra[c] = $urandom_range(0, len + 2);
      end
      g_rq[n-1] = 1;
      g_ra[n-1] = len + $urandom_range(0, 3);
      run_prog(len, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 2) == 0) ?
                 $urandom_range(1, n) : INF,
               -1);
      if ($urandom_range(0, 2) == 0)
        load_word($urandom_range(0, 40), rnd_word());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
